// File: rtl/disp_frame_sequencer_if.sv
// Bundles the configuration, host handshake and datapath strobe signals of the
// display frame sequencer. The sequencer uses the master view; the host and
// datapath use the slave view.
interface disp_frame_sequencer_if #(
    parameter int CW = 10
);
    logic          enable;
    logic [CW-1:0] cfg_hb;
    logic [CW-1:0] cfg_aip;
    logic [CW-1:0] cfg_vb;
    logic [CW-1:0] cfg_ail;
    logic          fill_done;
    logic          host_buf;
    logic          host_ready;
    logic [CW:0]   px_cnt;
    logic [CW:0]   line_cnt;
    logic          active;
    logic          frame_start;
    logic          re0;
    logic          re1;
    logic          inc_addr0;
    logic          inc_addr1;
    logic          reset_addr0;
    logic          reset_addr1;
    logic          sel_buf0;
    logic          sel_buf1;
    logic          sel_blank;
    logic          underrun;

    modport master (
        input  enable, cfg_hb, cfg_aip, cfg_vb, cfg_ail, fill_done,
        output host_buf, host_ready, px_cnt, line_cnt, active, frame_start,
               re0, re1, inc_addr0, inc_addr1, reset_addr0, reset_addr1,
               sel_buf0, sel_buf1, sel_blank, underrun
    );

    modport slave (
        output enable, cfg_hb, cfg_aip, cfg_vb, cfg_ail, fill_done,
        input  host_buf, host_ready, px_cnt, line_cnt, active, frame_start,
               re0, re1, inc_addr0, inc_addr1, reset_addr0, reset_addr1,
               sel_buf0, sel_buf1, sel_blank, underrun
    );
endinterface

// File: rtl/disp_frame_sequencer.sv
// Display frame sequencer: runs the raster counters, owns the ping-pong
// buffer state (EMPTY/FULL/READING) shared between host fill and display read,
// and produces the read, address and frame-mux strobes for the datapath.
// Frame-level decisions (config latch, buffer pick, release) are all taken on
// the clock edge that enters a frame-start cycle.
module disp_frame_sequencer #(
    parameter int CW = 10
) (
    input logic                    clk,
    input logic                    reset,
    disp_frame_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FULL    = 2'd1,
        BUF_READING = 2'd2
    } buf_state_t;

    localparam logic [CW:0] ONE = (CW+1)'(1);

    buf_state_t    buf_state [2];
    logic          host_buf_q;
    logic          running;
    logic [CW:0]   px_q;
    logic [CW:0]   line_q;
    logic [CW-1:0] hb_q;
    logic [CW-1:0] vb_q;
    logic [CW:0]   len_q;
    logic [CW:0]   height_q;
    logic          rd_valid;
    logic          rd_buf;
    logic          underrun_q;
    logic          frame_start_q;
    logic          rst_addr0_q;
    logic          rst_addr1_q;

    logic          last_px;
    logic          new_frame;
    logic          pick_valid;
    logic          pick_buf;
    logic [CW-1:0] aip_c;
    logic [CW-1:0] ail_c;
    logic [CW:0]   len_next;
    logic [CW:0]   height_next;
    logic          active_c;
    logic          sel0_c;
    logic          sel1_c;

    // Frame boundary detection, clamped config and the buffer pick, all from pre-update registers.
    always_comb begin
        last_px     = (px_q == len_q - ONE);
        new_frame   = !running || (last_px && (line_q == height_q - ONE));
        aip_c       = (bus.cfg_aip == '0) ? CW'(1) : bus.cfg_aip;
        ail_c       = (bus.cfg_ail == '0) ? CW'(1) : bus.cfg_ail;
        len_next    = {1'b0, bus.cfg_hb} + {1'b0, aip_c};
        height_next = {1'b0, bus.cfg_vb} + {1'b0, ail_c};
        pick_valid  = 1'b0;
        pick_buf    = 1'b0;
        if (buf_state[0] == BUF_FULL && buf_state[1] == BUF_FULL) begin
            pick_valid = 1'b1;
            pick_buf   = host_buf_q;
        end else if (buf_state[0] == BUF_FULL) begin
            pick_valid = 1'b1;
            pick_buf   = 1'b0;
        end else if (buf_state[1] == BUF_FULL) begin
            pick_valid = 1'b1;
            pick_buf   = 1'b1;
        end
    end

    // Raster counters, buffer ownership and frame-start strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_state[0]  <= BUF_EMPTY;
            buf_state[1]  <= BUF_EMPTY;
            host_buf_q    <= 1'b0;
            running       <= 1'b0;
            px_q          <= '0;
            line_q        <= '0;
            hb_q          <= '0;
            vb_q          <= '0;
            len_q         <= ONE;
            height_q      <= ONE;
            rd_valid      <= 1'b0;
            rd_buf        <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
            rst_addr0_q   <= 1'b0;
            rst_addr1_q   <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            rst_addr0_q   <= 1'b0;
            rst_addr1_q   <= 1'b0;

            // The host only ever writes an EMPTY buffer, so this never collides with the read side.
            if (bus.fill_done && buf_state[host_buf_q] == BUF_EMPTY) begin
                buf_state[host_buf_q] <= BUF_FULL;
                host_buf_q            <= ~host_buf_q;
            end

            if (!bus.enable) begin
                running  <= 1'b0;
                px_q     <= '0;
                line_q   <= '0;
                rd_valid <= 1'b0;
                if (rd_valid) begin
                    buf_state[rd_buf] <= BUF_FULL;
                end
            end else begin
                running <= 1'b1;
                if (new_frame) begin
                    px_q          <= '0;
                    line_q        <= '0;
                    frame_start_q <= 1'b1;
                    hb_q          <= bus.cfg_hb;
                    vb_q          <= bus.cfg_vb;
                    len_q         <= len_next;
                    height_q      <= height_next;
                    if (rd_valid) begin
                        buf_state[rd_buf] <= BUF_EMPTY;
                    end
                    if (pick_valid) begin
                        buf_state[pick_buf] <= BUF_READING;
                        rd_valid            <= 1'b1;
                        rd_buf              <= pick_buf;
                        rst_addr0_q         <= ~pick_buf;
                        rst_addr1_q         <= pick_buf;
                    end else begin
                        rd_valid   <= 1'b0;
                        underrun_q <= 1'b1;
                    end
                end else if (last_px) begin
                    px_q   <= '0;
                    line_q <= line_q + ONE;
                end else begin
                    px_q <= px_q + ONE;
                end
            end
        end
    end

    assign active_c = running && (px_q >= {1'b0, hb_q}) && (line_q >= {1'b0, vb_q});
    assign sel0_c   = active_c && rd_valid && !rd_buf;
    assign sel1_c   = active_c && rd_valid && rd_buf;

    assign bus.host_buf    = host_buf_q;
    assign bus.host_ready  = (buf_state[host_buf_q] == BUF_EMPTY);
    assign bus.px_cnt      = px_q;
    assign bus.line_cnt    = line_q;
    assign bus.active      = active_c;
    assign bus.frame_start = frame_start_q;
    assign bus.re0         = sel0_c;
    assign bus.re1         = sel1_c;
    assign bus.inc_addr0   = sel0_c;
    assign bus.inc_addr1   = sel1_c;
    assign bus.reset_addr0 = rst_addr0_q;
    assign bus.reset_addr1 = rst_addr1_q;
    assign bus.sel_buf0    = sel0_c;
    assign bus.sel_buf1    = sel1_c;
    assign bus.sel_blank   = !(sel0_c || sel1_c);
    assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_disp_frame_sequencer.sv
// Directed bench for disp_frame_sequencer: per-frame expectations are queued
// as each scenario is set up and compared against counts gathered over the frame.
module tb_disp_frame_sequencer;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    typedef struct {
        int active_n;
        int rd0_n;
        int rd1_n;
        int blank_n;
        int rst0_n;
        int rst1_n;
        bit und;
        bit hr;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    disp_frame_sequencer_if #(.CW(10)) bus ();

    disp_frame_sequencer #(.CW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit fill, input bit en);
        bus.fill_done = fill;
        bus.enable    = en;
        @(negedge clk);
        bus.fill_done = 1'b0;
    endtask

    task automatic doReset();
        bus.enable    = 1'b0;
        bus.fill_done = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pushExpect(input int a, input int r0, input int r1, input int bl,
                              input int s0, input int s1, input bit u, input bit h);
        frame_exp_t e;
        e.active_n = a;
        e.rd0_n    = r0;
        e.rd1_n    = r1;
        e.blank_n  = bl;
        e.rst0_n   = s0;
        e.rst1_n   = s1;
        e.und      = u;
        e.hr       = h;
        exp_q.push_back(e);
    endtask

    task automatic runFrame(input string tag, input int len, input int hb, input int vb, input bit fill_at_start);
        int guard;
        int act_n, rd0_n, rd1_n, blank_n, rst0_n, rst1_n, fs_n, bad_n;
        logic und_s, hr_s;
        frame_exp_t e;
        guard = 0;
        while (bus.frame_start !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, " start_seen"}, 32'(guard < 200), 1);
        act_n = 0; rd0_n = 0; rd1_n = 0; blank_n = 0;
        rst0_n = 0; rst1_n = 0; fs_n = 0; bad_n = 0;
        und_s = bus.underrun;
        hr_s  = bus.host_ready;
        for (int i = 0; i < len; i++) begin
            if (bus.active) act_n++;
            if (bus.active && !(int'(bus.px_cnt) >= hb && int'(bus.line_cnt) >= vb)) bad_n++;
            if (bus.sel_buf0) rd0_n++;
            if (bus.sel_buf1) rd1_n++;
            if (bus.sel_blank) blank_n++;
            if (int'(bus.sel_buf0) + int'(bus.sel_buf1) + int'(bus.sel_blank) != 1) bad_n++;
            if (bus.re0 !== bus.sel_buf0 || bus.inc_addr0 !== bus.sel_buf0 ||
                bus.re1 !== bus.sel_buf1 || bus.inc_addr1 !== bus.sel_buf1) bad_n++;
            if (bus.reset_addr0) rst0_n++;
            if (bus.reset_addr1) rst1_n++;
            if ((bus.reset_addr0 || bus.reset_addr1) && i != 0) bad_n++;
            if (bus.frame_start) fs_n++;
            bus.fill_done = (i == 0) ? fill_at_start : 1'b0;
            @(negedge clk);
        end
        bus.fill_done = 1'b0;
        checkOutput({tag, " fs_in_frame"}, fs_n, 1);
        checkOutput({tag, " bad_cycles"}, bad_n, 0);
        checkOutput({tag, " next_fs"}, bus.frame_start, 1);
        checkOutput({tag, " next_px"}, bus.px_cnt, 0);
        checkOutput({tag, " next_line"}, bus.line_cnt, 0);
        if (exp_q.size() == 0) begin
            checkOutput({tag, " exp_q_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, " active_n"}, act_n, e.active_n);
            checkOutput({tag, " rd0_n"}, rd0_n, e.rd0_n);
            checkOutput({tag, " rd1_n"}, rd1_n, e.rd1_n);
            checkOutput({tag, " blank_n"}, blank_n, e.blank_n);
            checkOutput({tag, " rst0_n"}, rst0_n, e.rst0_n);
            checkOutput({tag, " rst1_n"}, rst1_n, e.rst1_n);
            checkOutput({tag, " underrun"}, und_s, e.und);
            checkOutput({tag, " host_ready"}, hr_s, e.hr);
        end
    endtask

    initial begin
        int guard;
        int cnt;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.enable    = 1'b0;
        bus.fill_done = 1'b0;
        bus.cfg_hb  = 10'd2;
        bus.cfg_aip = 10'd4;
        bus.cfg_vb  = 10'd1;
        bus.cfg_ail = 10'd2;

        // Reset state
        doReset();
        checkOutput("rst px", bus.px_cnt, 0);
        checkOutput("rst line", bus.line_cnt, 0);
        checkOutput("rst sel_blank", bus.sel_blank, 1);
        checkOutput("rst sel_buf0", bus.sel_buf0, 0);
        checkOutput("rst re0", bus.re0, 0);
        checkOutput("rst reset_addr0", bus.reset_addr0, 0);
        checkOutput("rst frame_start", bus.frame_start, 0);
        checkOutput("rst active", bus.active, 0);
        checkOutput("rst host_buf", bus.host_buf, 0);
        checkOutput("rst host_ready", bus.host_ready, 1);
        checkOutput("rst underrun", bus.underrun, 0);

        // A: no fills, blank frames with underrun
        pushExpect(8, 0, 0, 18, 0, 0, 1, 1);
        pushExpect(8, 0, 0, 18, 0, 0, 1, 1);
        applyStimulus(1'b0, 1'b1);
        runFrame("A1", 18, 2, 1, 1'b0);
        runFrame("A2", 18, 2, 1, 1'b0);

        // B: single fill of buf0 before enable
        doReset();
        applyStimulus(1'b1, 1'b0);
        checkOutput("B host_buf", bus.host_buf, 1);
        checkOutput("B host_ready", bus.host_ready, 1);
        pushExpect(8, 8, 0, 10, 1, 0, 0, 1);
        applyStimulus(1'b0, 1'b1);
        runFrame("B1", 18, 2, 1, 1'b0);
        checkOutput("B post host_buf", bus.host_buf, 1);
        checkOutput("B post host_ready", bus.host_ready, 1);

        // C: both buffers filled, read in order
        doReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("C host_buf", bus.host_buf, 0);
        checkOutput("C host_ready", bus.host_ready, 0);
        pushExpect(8, 8, 0, 10, 1, 0, 0, 0);
        pushExpect(8, 0, 8, 10, 0, 1, 0, 1);
        applyStimulus(1'b0, 1'b1);
        runFrame("C1", 18, 2, 1, 1'b0);
        runFrame("C2", 18, 2, 1, 1'b0);

        // D: fill lands on the frame-start cycle
        doReset();
        pushExpect(8, 0, 0, 18, 0, 0, 1, 1);
        pushExpect(8, 8, 0, 10, 1, 0, 1, 1);
        applyStimulus(1'b0, 1'b1);
        runFrame("D1", 18, 2, 1, 1'b1);
        runFrame("D2", 18, 2, 1, 1'b0);

        // E: enable dropped mid-frame while reading buf1, then resumed
        doReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        pushExpect(8, 8, 0, 10, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b1);
        runFrame("E1", 18, 2, 1, 1'b0);
        cnt   = 0;
        guard = 0;
        while (!(bus.px_cnt == 11'd3 && bus.line_cnt == 11'd1) && guard < 100) begin
            if (bus.re1) cnt++;
            @(negedge clk);
            guard++;
        end
        if (bus.re1) cnt++;
        checkOutput("E reach l1p3", 32'(guard < 100), 1);
        checkOutput("E partial rd1", cnt, 2);
        bus.enable = 1'b0;
        @(negedge clk);
        checkOutput("E drop px", bus.px_cnt, 0);
        checkOutput("E drop line", bus.line_cnt, 0);
        checkOutput("E drop sel_blank", bus.sel_blank, 1);
        checkOutput("E drop re1", bus.re1, 0);
        checkOutput("E drop frame_start", bus.frame_start, 0);
        checkOutput("E drop underrun", bus.underrun, 0);
        pushExpect(8, 0, 8, 10, 0, 1, 0, 1);
        bus.enable = 1'b1;
        @(negedge clk);
        runFrame("E2", 18, 2, 1, 1'b0);

        // F: clamped configuration, then asynchronous reset mid-frame
        doReset();
        bus.cfg_hb  = 10'd1;
        bus.cfg_aip = 10'd0;
        bus.cfg_vb  = 10'd0;
        bus.cfg_ail = 10'd0;
        applyStimulus(1'b1, 1'b0);
        pushExpect(1, 1, 0, 1, 1, 0, 0, 1);
        pushExpect(1, 0, 0, 2, 0, 0, 1, 1);
        applyStimulus(1'b0, 1'b1);
        runFrame("F1", 2, 1, 0, 1'b0);
        runFrame("F2", 2, 1, 0, 1'b0);
        @(negedge clk);
        checkOutput("F pre px", bus.px_cnt, 1);
        checkOutput("F pre active", bus.active, 1);
        reset = 1'b1;
        #1;
        checkOutput("F async px", bus.px_cnt, 0);
        checkOutput("F async active", bus.active, 0);
        checkOutput("F async sel_blank", bus.sel_blank, 1);
        checkOutput("F async host_buf", bus.host_buf, 0);
        checkOutput("F async host_ready", bus.host_ready, 1);
        checkOutput("F async underrun", bus.underrun, 0);
        checkOutput("F async frame_start", bus.frame_start, 0);
        @(negedge clk);
        reset      = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/disp_frame_sequencer.md
Name: disp_frame_sequencer

Overview:
- Sequences the display datapath's two ping-pong pixel buffers (Buf0/Buf1) and their address counters against a programmable raster.
- Generates pixel and line counts with horizontal/vertical blanking from HB/AIP/VB/AIL configuration.
- Arbitrates buffer ownership between the host fill side and the display read side.
- Drives the read-enable, address-counter and frame-mux select strobes the datapath consumes.

Parameters:
- CW, 10, width of configuration fields; pixel/line counters are CW+1 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  raster run enable
- cfg_hb  in  CW  horizontal blank pixels per line
- cfg_aip  in  CW  active pixels per line
- cfg_vb  in  CW  vertical blank lines per frame
- cfg_ail  in  CW  active lines per frame
- fill_done  in  1  host pulse: buffer host_buf completely written
- host_buf  out  1  buffer index the host may write
- host_ready  out  1  host_buf is EMPTY and writable
- px_cnt  out  CW+1  current pixel within line
- line_cnt  out  CW+1  current line within frame
- active  out  1  current pixel is in active region
- frame_start  out  1  one-cycle pulse at px 0 / line 0
- re0, re1  out  1  buffer read enables
- inc_addr0, inc_addr1  out  1  address counter increments
- reset_addr0, reset_addr1  out  1  address counter clears
- sel_buf0, sel_buf1, sel_blank  out  1  frame mux selects, exactly one high
- underrun  out  1  sticky: a frame started with no FULL buffer

Behaviour:
- Reset values:
  - px_cnt = 0, line_cnt = 0; all strobes 0 except sel_blank = 1.
  - host_buf = 0, host_ready = 1, underrun = 0.
  - Both buffers EMPTY; read pointer invalid.
- Config latch:
  - cfg_* are sampled only on the cycle a frame starts.
  - cfg_aip = 0 and cfg_ail = 0 are each clamped to 1.
  - Line length L = hb + aip, frame height F = vb + ail, both computed CW+1 bits wide (no overflow).
- Raster:
  - While enable = 1, px_cnt increments every cycle and wraps L-1 -> 0.
  - line_cnt increments on each px wrap and wraps F-1 -> 0.
  - active = (px_cnt >= hb) && (line_cnt >= vb).
  - frame_start is high on the first cycle after enable rises, and on every subsequent px = 0 / line = 0 cycle.
- Buffer states, 2 bits per buffer: EMPTY, FULL, READING.
- Host side:
  - host_ready = (state[host_buf] == EMPTY).
  - fill_done with host_ready: state[host_buf] <= FULL and host_buf toggles.
  - fill_done without host_ready is ignored.
- Frame-start selection, evaluated on registered (pre-update) states:
  - Both FULL: choose host_buf (the older buffer).
  - One FULL: choose it.
  - None FULL: no buffer for this frame, sel_blank for the whole frame, underrun <= 1.
  - The chosen buffer becomes READING.
  - reset_addrN pulses for one cycle concurrent with frame_start for the chosen buffer N.
- Read:
  - reN = inc_addrN = sel_bufN = active && READING buffer is N.
  - sel_blank = !(sel_buf0 || sel_buf1).
- End of frame (last px of line F-1): the READING buffer becomes EMPTY on the wrap edge.
  - The new selection on that same edge uses pre-update states, so the released buffer is never re-picked.
- Simultaneous events:
  - fill_done on a frame-start cycle: the newly filled buffer is not eligible until the next frame.
  - fill_done on the release edge for the same buffer cannot occur, because host_ready is low while that buffer is READING.
- enable deassert mid-frame:
  - Counters return to 0 next cycle.
  - The READING buffer returns to FULL (not consumed).
  - All strobes go low and sel_blank goes high.
- Asynchronous reset mid-frame forces all reset values immediately.
- underrun clears only on reset.

Test Plan:
- Config hb=2, aip=4, vb=1, ail=2, no fills, enable=1 -> L=6, F=3, frame_start every 18 cycles; active on px 2..5 of lines 1..2 (8 cycles/frame); sel_blank constant; underrun = 1 after first frame_start.
- Fill buf0 before enable -> frame 1: reset_addr0 pulses with frame_start, inc_addr0/re0/sel_buf0 high for exactly 8 cycles; buf0 EMPTY after the wrap, host_ready = 1 with host_buf = 1.
- Fill buf0 then buf1 -> frame 1 reads buf0, frame 2 reads buf1; host_buf = 0, host_ready = 0 until frame 1 ends.
- fill_done asserted exactly on a frame_start cycle with both buffers EMPTY -> that frame is blank with underrun set; the next frame reads the filled buffer.
- Drop enable at line 1, px 3 while reading buf1 -> counters 0 next cycle, buf1 state FULL; re-enable -> buf1 re-read from reset_addr1.
- cfg_aip = 0, cfg_ail = 0, hb = 1, vb = 0 -> clamped to L=2, F=1; active at px 1 only; assert reset mid-frame -> all outputs at reset values asynchronously.
